alu_reg8: RTL and testbench



---
 rtl/alu_reg8.sv | 53 +++++
 tb/tb_alu_reg8.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_reg8.sv
// rtl/alu_reg8.sv - 16-function ALU with a single registered result
module alu_reg8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out
);

  logic [WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]   w_quot;
  logic [2*WIDTH-1:0] w_prod;

  assign w_prod = A * B;

  // A zero divisor yields all ones instead of relying on simulator/synth behaviour
  assign w_quot = (B == '0) ? {WIDTH{1'b1}} : (A / B);

  always_comb begin
    w_result = '0;
    unique case (ALU_Sel)
      4'h0: w_result = A + B;
      4'h1: w_result = A - B;
      4'h2: w_result = w_prod[WIDTH-1:0];
      4'h3: w_result = w_quot;
      4'h4: w_result = {A[WIDTH-2:0], 1'b0};
      4'h5: w_result = {1'b0, A[WIDTH-1:1]};
      4'h6: w_result = {A[WIDTH-2:0], A[WIDTH-1]};
      4'h7: w_result = {A[0], A[WIDTH-1:1]};
      4'h8: w_result = A & B;
      4'h9: w_result = A | B;
      4'hA: w_result = A ^ B;
      4'hB: w_result = ~(A | B);
      4'hC: w_result = ~(A & B);
      4'hD: w_result = ~(A ^ B);
      4'hE: w_result = {{(WIDTH-1){1'b0}}, (A > B)};
      4'hF: w_result = {{(WIDTH-1){1'b0}}, (A == B)};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Out <= '0;
    end else begin
      ALU_Out <= w_result;
    end
  end

endmodule

// File: tb/tb_alu_reg8.sv
// tb/tb_alu_reg8.sv - directed self-checking bench for alu_reg8
module tb_alu_reg8;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;

  int n_total;
  int n_bad;

  alu_reg8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .ALU_Sel (ALU_Sel),
    .ALU_Out (ALU_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the following rising edge
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                    input logic [3:0] sel, input logic [7:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    ALU_Sel = sel;
    @(posedge clk);
    #1;
    chk(tag, ALU_Out, exp);
  endtask

  logic [7:0] sweep_exp [16];

  initial begin
    n_total = 0;
    n_bad   = 0;
    sweep_exp = '{8'h05, 8'h01, 8'h06, 8'h01, 8'h06, 8'h01, 8'h06, 8'h81,
                  8'h02, 8'h03, 8'h01, 8'hFC, 8'hFD, 8'hFE, 8'h01, 8'h00};

    rst_n = 1'b0;
    A = 8'h12;
    B = 8'h34;
    ALU_Sel = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", ALU_Out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      op($sformatf("sweep_sel%0h", i), 8'h03, 8'h02, i[3:0], sweep_exp[i]);
    end

    op("add_wrap", 8'hFF, 8'h01, 4'h0, 8'h00);
    op("sub_wrap", 8'h02, 8'h03, 4'h1, 8'hFF);
    op("mul_wrap", 8'h10, 8'h10, 4'h2, 8'h00);
    op("shl_msb",  8'h80, 8'hAA, 4'h4, 8'h00);
    op("rol_msb",  8'h80, 8'h55, 4'h6, 8'h01);
    op("shr_lsb",  8'h01, 8'hFF, 4'h5, 8'h00);
    op("ror_lsb",  8'h01, 8'h00, 4'h7, 8'h80);
    op("div_zero", 8'h37, 8'h00, 4'h3, 8'hFF);
    op("div_ff10", 8'hFF, 8'h10, 4'h3, 8'h0F);
    op("gt_equal", 8'h5A, 8'h5A, 4'hE, 8'h00);
    op("eq_equal", 8'h5A, 8'h5A, 4'hF, 8'h01);
    op("gt_unsig", 8'h80, 8'h7F, 4'hE, 8'h01);
    op("gt_less",  8'h7F, 8'h80, 4'hE, 8'h00);
    op("eq_diff",  8'h5A, 8'h5B, 4'hF, 8'h00);

    // Latency: inputs changed between edges must not reach the output until the next edge
    op("lat_first", 8'h03, 8'h02, 4'h0, 8'h05);
    #2;
    A = 8'h04;
    B = 8'h04;
    ALU_Sel = 4'h2;
    #1;
    chk("lat_hold1", ALU_Out, 8'h05);
    @(negedge clk);
    A = 8'h01;
    B = 8'h01;
    ALU_Sel = 4'h0;
    #2;
    chk("lat_hold2", ALU_Out, 8'h05);
    @(posedge clk);
    #1;
    chk("lat_capture", ALU_Out, 8'h02);

    // Asynchronous clear mid-cycle, no clock edge in between
    op("pre_reset", 8'hA5, 8'h0F, 4'h9, 8'hAF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", ALU_Out, 8'h00);
    @(posedge clk);
    #1;
    chk("clear_edge", ALU_Out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release", ALU_Out, 8'hAF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
